// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared opcode constants and buffer entry type for the fetch stage
package fetch_pkg;
  localparam int FETCH_IW  = 16;
  localparam int FETCH_AW  = 8;
  localparam int OPC_WIDTH = 3;

  localparam logic [OPC_WIDTH-1:0] OPC_LOAD  = 3'b000;
  localparam logic [OPC_WIDTH-1:0] OPC_STORE = 3'b100;
  localparam logic [OPC_WIDTH-1:0] OPC_HALT  = 3'b111;

  typedef struct packed {
    logic [FETCH_IW-1:0] instr;
    logic [FETCH_AW-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory port and fetch-to-decode handshake
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int IW = FETCH_IW,
  parameter int AW = FETCH_AW
);
  logic                 imem_en;
  logic [AW-1:0]        imem_addr;
  logic [IW-1:0]        imem_rdata;
  logic                 if_valid;
  logic [IW-1:0]        if_instr;
  logic [AW-1:0]        if_pc;
  logic [OPC_WIDTH-1:0] if_opcode;
  logic                 id_ready;

  modport master (
    output imem_en, imem_addr, if_valid, if_instr, if_pc, if_opcode,
    input  imem_rdata, id_ready
  );

  modport slave (
    input  imem_en, imem_addr, if_valid, if_instr, if_pc, if_opcode,
    output imem_rdata, id_ready
  );
endinterface

// File: rtl/fetch_buf2.sv
// rtl/fetch_buf2.sv - 2-entry FIFO holding fetched {instr, pc} words; head is entry 0
module fetch_buf2 #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) e0_d = push_data;
          else                 e1_d = push_data;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_d    = e1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Pop and push together: occupancy is unchanged, the new word lands behind the survivor.
          if (count_q == 2'd1) begin
            e0_d = push_data;
          end else begin
            e0_d = e1_q;
            e1_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign head  = e0_q;
  assign count = count_q;

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && count_q == 2'd2));
  underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && count_q == 2'd0));
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, issue and redirect logic feeding a 2-entry fetch buffer
// Build option: HALT_ON_OPCODE_EN stops issue after fetching an OPC_HALT instruction.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int            IW       = FETCH_IW,
  parameter int            AW       = FETCH_AW,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_en,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          halted,
  fetch_unit_if.master  bus
);
  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] rd_pc_q, rd_pc_d;
  logic          pending_q, pending_d;
  logic          kill_q, kill_d;
  logic          halt_stop;
  logic          consume, capture, issue;
  logic [2:0]    occupancy;
  logic [1:0]    count;
  entry_t        head, push_entry;

  assign consume    = bus.if_valid && bus.id_ready;
  assign capture    = pending_q && !kill_q;
  // Slots already spoken for once this edge settles: stored words plus the read in flight.
  assign occupancy  = {1'b0, count} + {2'b00, pending_q} - {2'b00, consume};
  assign issue      = rst_n && fetch_en && !redirect_valid && !halt_stop && (occupancy < 3'd2);
  assign push_entry = '{instr: bus.imem_rdata, pc: rd_pc_q};

  always_comb begin
    pc_d      = pc_q;
    rd_pc_d   = rd_pc_q;
    pending_d = issue;
    kill_d    = kill_q && pending_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc;
      kill_d = pending_q;
    end else if (issue) begin
      pc_d    = pc_q + AW'(1);
      rd_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      rd_pc_q   <= '0;
      pending_q <= 1'b0;
      kill_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      rd_pc_q   <= rd_pc_d;
      pending_q <= pending_d;
      kill_q    <= kill_d;
    end
  end

`ifdef HALT_ON_OPCODE_EN
  logic halted_q, halted_d;

  always_comb begin
    halted_d = halted_q;
    if (redirect_valid) begin
      halted_d = 1'b0;
    end else if (capture && (bus.imem_rdata[IW-1 -: OPC_WIDTH] == OPC_HALT)) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end

  assign halted    = halted_q;
  assign halt_stop = halted_q;
`else
  assign halted    = 1'b0;
  assign halt_stop = 1'b0;
`endif

  fetch_buf2 #(.W($bits(entry_t))) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (push_entry),
    .pop       (consume),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

  assign bus.imem_en   = issue;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = (count != 2'd0);
  assign bus.if_instr  = head.instr;
  assign bus.if_pc     = head.pc;
  assign bus.if_opcode = head.instr[IW-1 -: OPC_WIDTH];
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit (RESET_PC=0 and RESET_PC=8'hFE instances)
module tb_fetch_unit;
  logic       clk;
  logic       rst_n;
  logic       fetch_en, redirect_valid;
  logic [7:0] redirect_pc;
  logic       halted;
  logic       fetch_en2, redirect_valid2;
  logic [7:0] redirect_pc2;
  logic       halted2;
  logic [15:0] mem [256];
  int checks, errors;

  fetch_unit_if #(.IW(16), .AW(8)) bus ();
  fetch_unit_if #(.IW(16), .AW(8)) bus2 ();

  fetch_unit #(.IW(16), .AW(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halted(halted), .bus(bus)
  );

  fetch_unit #(.IW(16), .AW(8), .RESET_PC(8'hFE)) dut2 (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en2), .redirect_valid(redirect_valid2),
    .redirect_pc(redirect_pc2), .halted(halted2), .bus(bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (bus.imem_en)  bus.imem_rdata  <= mem[bus.imem_addr];
  always @(posedge clk) if (bus2.imem_en) bus2.imem_rdata <= mem[bus2.imem_addr];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    rst_n = 1'b0; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = 8'h00;
    bus.id_ready = 1'b1;
    fetch_en2 = 1'b1; redirect_valid2 = 1'b0; redirect_pc2 = 8'h00;
    bus2.id_ready = 1'b1;

    repeat (3) tick();
    #1;
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_imem_en", bus.imem_en, 0);
    chk("rst_if_instr", bus.if_instr, 0);
    chk("rst_if_pc", bus.if_pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_halted2", halted2, 0);

    // cycle 0 after reset release
    tick(); rst_n = 1'b1; #1;
    chk("c0_imem_en", bus.imem_en, 1);
    chk("c0_imem_addr", bus.imem_addr, 8'h00);
    tick(); #1;
    chk("c1_imem_addr", bus.imem_addr, 8'h01);
    chk("c1_if_valid", bus.if_valid, 0);
    chk("w_c1_addr", bus2.imem_addr, 8'hFF);
    tick(); #1;
    chk("c2_if_valid", bus.if_valid, 1);
    chk("c2_if_instr", bus.if_instr, 16'h1000);
    chk("c2_if_pc", bus.if_pc, 8'h00);
    chk("c2_if_opcode", bus.if_opcode, 3'b000);
    chk("c2_imem_addr", bus.imem_addr, 8'h02);
    chk("w_c2_if_pc", bus2.if_pc, 8'hFE);
    chk("w_c2_addr", bus2.imem_addr, 8'h00);

    // decode stalls cycles 3..7
    tick(); bus.id_ready = 1'b0; #1;
    chk("c3_imem_en", bus.imem_en, 0);
    chk("c3_if_instr", bus.if_instr, 16'h1001);
    chk("w_c3_if_pc", bus2.if_pc, 8'hFF);
    tick(); #1;
    chk("c4_imem_en", bus.imem_en, 0);
    chk("c4_if_valid", bus.if_valid, 1);
    chk("w_c4_if_pc", bus2.if_pc, 8'h00);
    chk("w_c4_if_instr", bus2.if_instr, 16'h1000);
    tick(); #1;
    chk("w_c5_if_pc", bus2.if_pc, 8'h01);
    tick(); tick(); #1;
    chk("c7_imem_en", bus.imem_en, 0);
    chk("c7_if_instr", bus.if_instr, 16'h1001);
    tick(); bus.id_ready = 1'b1; #1;
    chk("c8_if_instr", bus.if_instr, 16'h1001);
    chk("c8_imem_en", bus.imem_en, 1);
    chk("c8_imem_addr", bus.imem_addr, 8'h03);
    tick(); #1;
    chk("c9_if_instr", bus.if_instr, 16'h1002);
    tick(); #1;
    chk("c10_if_instr", bus.if_instr, 16'h1003);

    // redirect with a read in flight and an unconsumed head
    tick(); bus.id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h40; #1;
    chk("c11_if_instr", bus.if_instr, 16'h1004);
    chk("c11_imem_en", bus.imem_en, 0);
    tick(); redirect_valid = 1'b0; bus.id_ready = 1'b1; #1;
    chk("c12_if_valid", bus.if_valid, 0);
    chk("c12_imem_en", bus.imem_en, 1);
    chk("c12_imem_addr", bus.imem_addr, 8'h40);
    tick(); #1;
    chk("c13_if_valid", bus.if_valid, 0);
    tick(); #1;
    chk("c14_if_valid", bus.if_valid, 1);
    chk("c14_if_pc", bus.if_pc, 8'h40);
    chk("c14_if_instr", bus.if_instr, 16'h1040);

    // back-to-back redirects: last one wins
    tick(); redirect_valid = 1'b1; redirect_pc = 8'h80; #1;
    chk("c15_if_pc", bus.if_pc, 8'h41);
    chk("c15_imem_en", bus.imem_en, 0);
    tick(); redirect_pc = 8'h90; #1;
    chk("c16_if_valid", bus.if_valid, 0);
    chk("c16_imem_en", bus.imem_en, 0);
    tick(); redirect_valid = 1'b0; #1;
    chk("c17_imem_addr", bus.imem_addr, 8'h90);
    chk("c17_imem_en", bus.imem_en, 1);
    tick(); #1;
    chk("c18_if_valid", bus.if_valid, 0);
    tick(); #1;
    chk("c19_if_pc", bus.if_pc, 8'h90);
    chk("c19_if_instr", bus.if_instr, 16'h1090);

    // asynchronous reset pulse mid-cycle with buffer and read in flight
    tick(); #1;
    chk("c20_if_pc", bus.if_pc, 8'h91);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_if_valid", bus.if_valid, 0);
    chk("arst_imem_en", bus.imem_en, 0);
    chk("arst_w_if_valid", bus2.if_valid, 0);
    tick(); rst_n = 1'b1; #1;
    chk("r0_imem_addr", bus.imem_addr, 8'h00);
    chk("r0_imem_en", bus.imem_en, 1);
    chk("r0_if_valid", bus.if_valid, 0);
    tick(); #1;
    chk("r1_if_valid", bus.if_valid, 0);
    tick(); #1;
    chk("r2_if_pc", bus.if_pc, 8'h00);
    chk("r2_if_instr", bus.if_instr, 16'h1000);

    // opcode 3'b111 at address 3
    mem[3] = 16'hE000;
    tick(); rst_n = 1'b0;
    tick(); tick(); rst_n = 1'b1; #1;
    repeat (5) tick();
    #1;
    chk("h5_if_instr", bus.if_instr, 16'hE000);
    chk("h5_if_opcode", bus.if_opcode, 3'b111);
`ifdef HALT_ON_OPCODE_EN
    chk("h5_halted", halted, 1);
    chk("h5_imem_en", bus.imem_en, 0);
    tick(); #1;
    chk("h6_if_pc", bus.if_pc, 8'h04);
    chk("h6_imem_en", bus.imem_en, 0);
    tick(); redirect_valid = 1'b1; redirect_pc = 8'h10; #1;
    chk("h7_if_valid", bus.if_valid, 0);
    chk("h7_halted", halted, 1);
    tick(); redirect_valid = 1'b0; #1;
    chk("h8_halted", halted, 0);
    chk("h8_imem_en", bus.imem_en, 1);
    chk("h8_imem_addr", bus.imem_addr, 8'h10);
    tick(); tick(); #1;
    chk("h10_if_pc", bus.if_pc, 8'h10);
    chk("h10_if_instr", bus.if_instr, 16'h1010);
`else
    chk("h5_halted", halted, 0);
    chk("h5_imem_en", bus.imem_en, 1);
    chk("h5_imem_addr", bus.imem_addr, 8'h05);
    tick(); #1;
    chk("h6_if_pc", bus.if_pc, 8'h04);
    tick(); #1;
    chk("h7_if_valid", bus.if_valid, 1);
    chk("h7_if_pc", bus.if_pc, 8'h05);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
